// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic weight-loading path.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Counter width that stays legal for the smallest array (size 2).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_SYSTOLIC_SIZE = 8;
  localparam int unsigned DEF_WEIGHT_WIDTH  = 8;
  localparam int unsigned DEF_CNT_W         = cnt_width(DEF_SYSTOLIC_SIZE);

  // Low bit of column col's weight inside a flattened row.
  function automatic int unsigned weight_lo(input int unsigned col, input int unsigned width);
    return col * width;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register carrying {valid, data} for one skewed column.
module skew_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/weight_skew_loader.sv
// Streams one weight tile into the systolic array in 45-degree skewed order,
// zeroing columns flagged faulty at tile start.
module weight_skew_loader
  import systolic_pkg::*;
#(
  parameter int unsigned SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
  parameter int unsigned WEIGHT_WIDTH  = DEF_WEIGHT_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [SYSTOLIC_SIZE-1:0]              pe_disable_in,
  input  logic                                  row_valid,
  output logic                                  row_ready,
  input  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] row_data,
  output logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] weight_out_flat,
  output logic [SYSTOLIC_SIZE-1:0]              weight_valid_out,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned CNT_W  = cnt_width(SYSTOLIC_SIZE);
  localparam int unsigned LANE_W = WEIGHT_WIDTH + 1;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_row_cnt;
  logic [CNT_W-1:0]         r_drain_cnt;
  logic [SYSTOLIC_SIZE-1:0] r_dis_mask;
  logic                     r_busy;
  logic                     r_row_ready;
  logic                     r_done;
  logic                     w_accept;

  assign w_accept  = row_valid & r_row_ready;
  assign row_ready = r_row_ready;
  assign busy      = r_busy;
  assign done      = r_done;

  // Tile sequencing; busy/row_ready are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_row_cnt   <= '0;
      r_drain_cnt <= '0;
      r_dis_mask  <= '0;
      r_busy      <= 1'b0;
      r_row_ready <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= LOAD;
            r_row_cnt   <= '0;
            r_drain_cnt <= '0;
            r_dis_mask  <= pe_disable_in;
            r_busy      <= 1'b1;
            r_row_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_row_cnt <= r_row_cnt + CNT_W'(1);
            if (r_row_cnt == CNT_W'(SYSTOLIC_SIZE - 1)) begin
              r_state     <= DRAIN;
              r_row_ready <= 1'b0;
              r_drain_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          r_drain_cnt <= r_drain_cnt + CNT_W'(1);
          if (r_drain_cnt == CNT_W'(SYSTOLIC_SIZE - 2)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_row_ready <= 1'b0;
        end
      endcase
    end
  end

  // Column c delays by c+1 stages; bubbles and disabled lanes enter as {0,0}.
  for (genvar c = 0; c < SYSTOLIC_SIZE; c++) begin : g_col
    logic              w_lane_en;
    logic [LANE_W-1:0] w_din;
    logic [LANE_W-1:0] w_dout;

    assign w_lane_en = w_accept & ~r_dis_mask[c];
    assign w_din     = w_lane_en
                     ? {1'b1, row_data[weight_lo(c, WEIGHT_WIDTH) +: WEIGHT_WIDTH]}
                     : '0;

    skew_delay_line #(
      .DEPTH (c + 1),
      .WIDTH (LANE_W)
    ) u_delay (
      .clk (clk),
      .rst (rst),
      .i_d (w_din),
      .o_q (w_dout)
    );

    assign weight_out_flat[weight_lo(c, WEIGHT_WIDTH) +: WEIGHT_WIDTH] = w_dout[WEIGHT_WIDTH-1:0];
    assign weight_valid_out[c] = w_dout[WEIGHT_WIDTH];
  end

endmodule

// File: tb/tb_weight_skew_loader.sv
// Scoreboard bench for weight_skew_loader: stimulus pushes expected column
// slots and done pulses; a negedge monitor pops and compares them.
module tb_weight_skew_loader;

  localparam int unsigned S = 8;
  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] d;
    int           cyc;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           start;
  logic [S-1:0]   pe_disable_in;
  logic           row_valid;
  logic           row_ready;
  logic [S*W-1:0] row_data;
  logic [S*W-1:0] weight_out_flat;
  logic [S-1:0]   weight_valid_out;
  logic           busy;
  logic           done;

  exp_t           col_q [S][$];
  int             done_q[$];
  int             checks;
  int             failures;
  int             cyc;
  bit             mon_en;
  logic [S-1:0]   cur_mask;
  exp_t           mon_e;
  logic [S*W-1:0] mon_z;
  int             last_acc;

  weight_skew_loader #(.SYSTOLIC_SIZE(S), .WEIGHT_WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .pe_disable_in    (pe_disable_in),
    .row_valid        (row_valid),
    .row_ready        (row_ready),
    .row_data         (row_data),
    .weight_out_flat  (weight_out_flat),
    .weight_valid_out (weight_valid_out),
    .busy             (busy),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  // Monitor: pops expectations whenever a column or done is presented.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_z = '0;
      for (int c = 0; c < S; c++) begin
        if (weight_valid_out[c]) begin
          if (col_q[c].size() == 0) begin
            chk($sformatf("col%0d_unexpected_valid", c), 64'(weight_valid_out[c]), 64'd0);
          end else begin
            mon_e = col_q[c].pop_front();
            chk($sformatf("col%0d_data", c), 64'(weight_out_flat[c*W +: W]), 64'(mon_e.d));
            chk($sformatf("col%0d_cycle", c), 64'(cyc), 64'(mon_e.cyc));
          end
        end else begin
          mon_z[c*W +: W] = weight_out_flat[c*W +: W];
        end
      end
      chk("invalid_lanes_zero", 64'(mon_z), 64'd0);
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
          chk("busy_in_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  function automatic logic [S*W-1:0] row_pat(input int r, input int base);
    logic [S*W-1:0] v;
    for (int c = 0; c < S; c++) v[c*W +: W] = W'(base + 8*r + c);
    return v;
  endfunction

  // Called just after a negedge; issues start for one cycle.
  task automatic do_start(input logic [S-1:0] mask, input bit valid_too);
    start         = 1'b1;
    pe_disable_in = mask;
    cur_mask      = mask;
    row_valid     = valid_too;
    row_data      = row_pat(0, 200);
    @(negedge clk);
    start     = 1'b0;
    row_valid = 1'b0;
    chk("row_ready_after_start", 64'(row_ready), 64'd1);
  endtask

  // Presents one row; the bench expects it accepted on the next edge.
  task automatic send_row(input int r, input int base);
    int a;
    int waited;
    row_valid = 1'b1;
    row_data  = row_pat(r, base);
    chk("row_ready_for_row", 64'(row_ready), 64'd1);
    waited = 0;
    while (!row_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    a = cyc + 1;
    for (int c = 0; c < S; c++) begin
      if (!cur_mask[c]) col_q[c].push_back('{d: W'(base + 8*r + c), cyc: a + c});
    end
    if (r == S - 1) done_q.push_back(a + S - 1);
    last_acc = a;
    @(negedge clk);
    row_valid = 1'b0;
  endtask

  task automatic idle_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic purge_from(input int e);
    for (int c = 0; c < S; c++)
      for (int i = col_q[c].size() - 1; i >= 0; i--)
        if (col_q[c][i].cyc >= e) col_q[c].delete(i);
    done_q.delete();
  endtask

  initial begin
    checks = 0; failures = 0; mon_en = 1'b0; last_acc = 0;
    rst = 1'b1; start = 1'b0; pe_disable_in = '0; row_valid = 1'b0;
    row_data = '0; cur_mask = '0;

    // Reset, then idle with start low.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_weights", 64'(weight_out_flat), 64'd0);
      chk("idle_valid",   64'(weight_valid_out), 64'd0);
      chk("idle_ctrl",    64'({busy, row_ready, done}), 64'd0);
    end
    mon_en = 1'b1;

    // Tile A: no bubbles; row_valid in the start cycle must not be taken.
    do_start('0, 1'b1);
    for (int r = 0; r < S; r++) send_row(r, 0);

    // Tile B started in tile A's done cycle; bubble after row 3; start while busy.
    idle_until(last_acc + S - 1);
    do_start('0, 1'b0);
    for (int r = 0; r < S; r++) begin
      if (r == 4) repeat (2) @(negedge clk);
      if (r == 5) start = 1'b1;
      send_row(r, 64);
      start = 1'b0;
    end

    // Tile C: columns 0 and 2 disabled; the mask input changes mid-tile.
    idle_until(last_acc + S + 2);
    do_start(8'b0000_0101, 1'b0);
    for (int r = 0; r < S; r++) begin
      send_row(r, 128);
      if (r == 2) pe_disable_in = '1;
    end
    pe_disable_in = '0;

    // Tile D: reset two cycles after the last accept discards the drain.
    idle_until(last_acc + S + 2);
    do_start('0, 1'b0);
    for (int r = 0; r < S; r++) send_row(r, 16);
    @(negedge clk);
    rst = 1'b1;
    purge_from(last_acc + 2);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_weights", 64'(weight_out_flat), 64'd0);
    chk("rst_valid",   64'(weight_valid_out), 64'd0);
    chk("rst_ctrl",    64'({busy, row_ready, done}), 64'd0);
    repeat (S + 3) @(negedge clk);
    chk("post_rst_idle", 64'({busy, row_ready}), 64'd0);

    for (int c = 0; c < S; c++) chk($sformatf("col%0d_missing", c), 64'(col_q[c].size()), 64'd0);
    chk("done_missing", 64'(done_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
